// File: rtl/hssi_reset_sequencer.sv
// ---------------------------------------------------------------------------
// hssi_reset_sequencer
//
// Bring-up and recovery sequencer for one HSSI port. Releases the PLL, TX and
// RX resets in that order. After each release it waits for the matching
// lock/ready status. Every wait has a timeout, and a bounded number of
// timeouts is retried before the sequencer parks in FAIL.
//
// Optional feature macro: HSSI_RST_SEQ_RX_RECOVER_EN
//   defined   : RX ready loss in RUN re-runs only the RX reset stage, and TX
//               stays usable while that happens.
//   undefined : RX ready loss in RUN triggers a full re-bring-up from PLL_RST.
//
// Ports
//   clk          : single clock, rising edge
//   rst_n        : synchronous active-low reset
//   restart_req  : one-cycle soft restart request (synchronous)
//   pll_locked   : asynchronous PLL lock status
//   tx_ready_in  : asynchronous TX PHY ready
//   rx_ready_in  : asynchronous RX PHY ready
//   pll_rst      : PLL reset, active-high
//   tx_rst       : TX PCS/PMA reset, active-high
//   rx_rst       : RX PCS/PMA reset, active-high
//   tx_ready     : TX link usable
//   rx_ready     : RX link usable
//   fail         : retries exhausted
//   state        : current FSM state code (debug/observability)
//   retry_cnt    : timeouts taken in the current bring-up
//
// Handshake note: there are no valid/ready transfers here. The status inputs
// are level signals. restart_req is a single-cycle pulse acted on the cycle
// after it is sampled.
// ---------------------------------------------------------------------------
module hssi_reset_sequencer #(
    parameter int CNTR_BITS    = 16,
    parameter int PLL_RST_CYC  = 16,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int TX_DLY       = 64,
    parameter int RX_DLY       = 64,
    parameter int RDY_TIMEOUT  = 65535,
    parameter int MAX_RETRY    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       restart_req,
    input  logic       pll_locked,
    input  logic       tx_ready_in,
    input  logic       rx_ready_in,
    output logic       pll_rst,
    output logic       tx_rst,
    output logic       rx_rst,
    output logic       tx_ready,
    output logic       rx_ready,
    output logic       fail,
    output logic [2:0] state,
    output logic [3:0] retry_cnt
);

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_TX_RST    = 3'd2,
        ST_WAIT_TX   = 3'd3,
        ST_RX_RST    = 3'd4,
        ST_WAIT_RX   = 3'd5,
        ST_RUN       = 3'd6,
        ST_FAIL      = 3'd7
    } state_e;

    // Terminal counter values: a timed state exits when cnt == N-1.
    localparam logic [CNTR_BITS-1:0] PLL_RST_LAST = CNTR_BITS'(PLL_RST_CYC - 1);
    localparam logic [CNTR_BITS-1:0] LOCK_LAST    = CNTR_BITS'(LOCK_TIMEOUT - 1);
    localparam logic [CNTR_BITS-1:0] TX_DLY_LAST  = CNTR_BITS'(TX_DLY - 1);
    localparam logic [CNTR_BITS-1:0] RX_DLY_LAST  = CNTR_BITS'(RX_DLY - 1);
    localparam logic [CNTR_BITS-1:0] RDY_LAST     = CNTR_BITS'(RDY_TIMEOUT - 1);
    localparam logic [3:0]           RETRY_LAST   = 4'(MAX_RETRY - 1);

    // ------------------------------------------------------------------
    // 3-flop synchronizers for the asynchronous status inputs
    // ------------------------------------------------------------------
    logic [2:0] lock_sync_q;
    logic [2:0] txr_sync_q;
    logic [2:0] rxr_sync_q;
    logic       lock_s;
    logic       txr_s;
    logic       rxr_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_sync_q <= 3'b000;
            txr_sync_q  <= 3'b000;
            rxr_sync_q  <= 3'b000;
        end else begin
            lock_sync_q <= {lock_sync_q[1:0], pll_locked};
            txr_sync_q  <= {txr_sync_q[1:0], tx_ready_in};
            rxr_sync_q  <= {rxr_sync_q[1:0], rx_ready_in};
        end
    end

    assign lock_s = lock_sync_q[2];
    assign txr_s  = txr_sync_q[2];
    assign rxr_s  = rxr_sync_q[2];

    // ------------------------------------------------------------------
    // State, counter, retry and registered outputs
    // ------------------------------------------------------------------
    state_e                 state_q, state_d;
    logic [CNTR_BITS-1:0]   cnt_q, cnt_d;
    logic [3:0]             retry_q, retry_d;
    logic                   pll_rst_q, pll_rst_d;
    logic                   tx_rst_q, tx_rst_d;
    logic                   rx_rst_q, rx_rst_d;
    logic                   tx_ready_q, tx_ready_d;
    logic                   rx_ready_q, rx_ready_d;
    logic                   fail_q, fail_d;
`ifdef HSSI_RST_SEQ_RX_RECOVER_EN
    // Set while RX is being re-brought-up from RUN so TX stays usable.
    logic                   tx_hold_q, tx_hold_d;
`endif

    logic lock_loss;
    logic tx_loss;
    logic rx_loss;
    logic timed_state;

    always_comb begin
        lock_loss   = !lock_s && (state_q inside {ST_TX_RST, ST_WAIT_TX, ST_RX_RST,
                                                  ST_WAIT_RX, ST_RUN});
        tx_loss     = !txr_s && (state_q inside {ST_RX_RST, ST_WAIT_RX, ST_RUN});
        rx_loss     = !rxr_s && (state_q == ST_RUN);
        timed_state = (state_q inside {ST_PLL_RST, ST_WAIT_LOCK, ST_TX_RST,
                                       ST_WAIT_TX, ST_RX_RST, ST_WAIT_RX});
    end

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
`ifdef HSSI_RST_SEQ_RX_RECOVER_EN
        tx_hold_d = tx_hold_q;
`endif
        if (restart_req) begin
            state_d = ST_PLL_RST;
            retry_d = 4'd0;
        end else if (lock_loss) begin
            state_d = ST_PLL_RST;
        end else if (tx_loss) begin
            state_d = ST_TX_RST;
        end else if (rx_loss) begin
`ifdef HSSI_RST_SEQ_RX_RECOVER_EN
            state_d   = ST_RX_RST;
            tx_hold_d = 1'b1;
`else
            state_d = ST_PLL_RST;
`endif
        end else begin
            case (state_q)
                ST_PLL_RST: begin
                    if (cnt_q == PLL_RST_LAST) state_d = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    // Status is checked before the timeout, so a lock arriving
                    // on the last cycle is a success.
                    if (lock_s) begin
                        state_d = ST_TX_RST;
                    end else if (cnt_q == LOCK_LAST) begin
                        if (retry_q == RETRY_LAST) begin
                            state_d = ST_FAIL;
                        end else begin
                            state_d = ST_PLL_RST;
                            retry_d = retry_q + 4'd1;
                        end
                    end
                end
                ST_TX_RST: begin
                    if (cnt_q == TX_DLY_LAST) state_d = ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    if (txr_s) begin
                        state_d = ST_RX_RST;
                    end else if (cnt_q == RDY_LAST) begin
                        if (retry_q == RETRY_LAST) begin
                            state_d = ST_FAIL;
                        end else begin
                            state_d = ST_TX_RST;
                            retry_d = retry_q + 4'd1;
                        end
                    end
                end
                ST_RX_RST: begin
                    if (cnt_q == RX_DLY_LAST) state_d = ST_WAIT_RX;
                end
                ST_WAIT_RX: begin
                    if (rxr_s) begin
                        state_d = ST_RUN;
                        retry_d = 4'd0;
                    end else if (cnt_q == RDY_LAST) begin
                        if (retry_q == RETRY_LAST) begin
                            state_d = ST_FAIL;
                        end else begin
                            state_d = ST_RX_RST;
                            retry_d = retry_q + 4'd1;
                        end
                    end
                end
                ST_RUN:  state_d = ST_RUN;
                ST_FAIL: state_d = ST_FAIL;
                default: state_d = ST_PLL_RST;
            endcase
        end

`ifdef HSSI_RST_SEQ_RX_RECOVER_EN
        // The TX hold only survives while the RX stage is being redone.
        if (!(state_d inside {ST_RX_RST, ST_WAIT_RX})) tx_hold_d = 1'b0;
`endif

        // Counter restarts on every state entry; restart_req from PLL_RST
        // counts as a fresh entry even though the code does not change.
        if (restart_req || (state_d != state_q)) begin
            cnt_d = '0;
        end else if (timed_state) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end

        // Outputs decoded from the next state so they line up with state.
        pll_rst_d  = (state_d inside {ST_PLL_RST, ST_FAIL});
        tx_rst_d   = (state_d inside {ST_PLL_RST, ST_WAIT_LOCK, ST_TX_RST, ST_FAIL});
        rx_rst_d   = (state_d inside {ST_PLL_RST, ST_WAIT_LOCK, ST_TX_RST,
                                      ST_WAIT_TX, ST_RX_RST, ST_FAIL});
        rx_ready_d = (state_d == ST_RUN);
        fail_d     = (state_d == ST_FAIL);
`ifdef HSSI_RST_SEQ_RX_RECOVER_EN
        tx_ready_d = (state_d == ST_RUN) || tx_hold_d;
`else
        tx_ready_d = (state_d == ST_RUN);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_PLL_RST;
            cnt_q      <= '0;
            retry_q    <= 4'd0;
            pll_rst_q  <= 1'b1;
            tx_rst_q   <= 1'b1;
            rx_rst_q   <= 1'b1;
            tx_ready_q <= 1'b0;
            rx_ready_q <= 1'b0;
            fail_q     <= 1'b0;
`ifdef HSSI_RST_SEQ_RX_RECOVER_EN
            tx_hold_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            retry_q    <= retry_d;
            pll_rst_q  <= pll_rst_d;
            tx_rst_q   <= tx_rst_d;
            rx_rst_q   <= rx_rst_d;
            tx_ready_q <= tx_ready_d;
            rx_ready_q <= rx_ready_d;
            fail_q     <= fail_d;
`ifdef HSSI_RST_SEQ_RX_RECOVER_EN
            tx_hold_q  <= tx_hold_d;
`endif
        end
    end

    assign pll_rst   = pll_rst_q;
    assign tx_rst    = tx_rst_q;
    assign rx_rst    = rx_rst_q;
    assign tx_ready  = tx_ready_q;
    assign rx_ready  = rx_ready_q;
    assign fail      = fail_q;
    assign state     = state_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_hssi_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_hssi_reset_sequencer
//
// Directed bench for hssi_reset_sequencer with small timing parameters.
// Expected outputs are packed as
//   {state[2:0], pll_rst, tx_rst, rx_rst, tx_ready, rx_ready, fail, retry_cnt[3:0]}
// Inputs are driven 1 time unit after a rising edge and outputs are sampled
// at that same point, after the edge's updates have settled.
// ---------------------------------------------------------------------------
module tb_hssi_reset_sequencer;

    localparam int CNTR_BITS    = 16;
    localparam int PLL_RST_CYC  = 4;
    localparam int LOCK_TIMEOUT = 100;
    localparam int TX_DLY       = 8;
    localparam int RX_DLY       = 8;
    localparam int RDY_TIMEOUT  = 100;
    localparam int MAX_RETRY    = 3;

    // ---------------- clock / reset ----------------
    logic       clk;
    logic       rst_n;
    logic       restart_req;
    logic       pll_locked;
    logic       tx_ready_in;
    logic       rx_ready_in;
    logic       pll_rst;
    logic       tx_rst;
    logic       rx_rst;
    logic       tx_ready;
    logic       rx_ready;
    logic       fail;
    logic [2:0] state;
    logic [3:0] retry_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    hssi_reset_sequencer #(
        .CNTR_BITS    (CNTR_BITS),
        .PLL_RST_CYC  (PLL_RST_CYC),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .TX_DLY       (TX_DLY),
        .RX_DLY       (RX_DLY),
        .RDY_TIMEOUT  (RDY_TIMEOUT),
        .MAX_RETRY    (MAX_RETRY)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .restart_req (restart_req),
        .pll_locked  (pll_locked),
        .tx_ready_in (tx_ready_in),
        .rx_ready_in (rx_ready_in),
        .pll_rst     (pll_rst),
        .tx_rst      (tx_rst),
        .rx_rst      (rx_rst),
        .tx_ready    (tx_ready),
        .rx_ready    (rx_ready),
        .fail        (fail),
        .state       (state),
        .retry_cnt   (retry_cnt)
    );

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        bit          rn;
        bit          rq;
        bit          lk;
        bit          tr;
        bit          rr;
        int          cyc;
        logic [12:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   total;
    int   bad;

    function automatic logic [12:0] ev(int st, bit p, bit t, bit r, bit tr, bit rr,
                                       bit f, int rc);
        return {3'(st), p, t, r, tr, rr, f, 4'(rc)};
    endfunction

    function automatic void add(string nm, bit rn, bit rq, bit lk, bit tr, bit rr,
                                int cyc, logic [12:0] ex);
        vec_t v;
        v.name = nm;
        v.rn   = rn;
        v.rq   = rq;
        v.lk   = lk;
        v.tr   = tr;
        v.rr   = rr;
        v.cyc  = cyc;
        v.exp  = ex;
        vecs.push_back(v);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(bit rn, bit rq, bit lk, bit tr, bit rr);
        rst_n       = rn;
        restart_req = rq;
        pll_locked  = lk;
        tx_ready_in = tr;
        rx_ready_in = rr;
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(string nm, logic [12:0] exp);
        logic [12:0] got;
        got = {state, pll_rst, tx_rst, rx_rst, tx_ready, rx_ready, fail, retry_cnt};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got st=%0d rst=%b rdy=%b fail=%b retry=%0d, want st=%0d rst=%b rdy=%b fail=%b retry=%0d",
                     nm, got[12:10], got[9:7], got[6:5], got[4], got[3:0],
                     exp[12:10], exp[9:7], exp[6:5], exp[4], exp[3:0]);
        end
    endtask

    logic [12:0] e_rst;
    logic [12:0] e_run;

    initial begin
        total = 0;
        bad   = 0;
        drive(0, 0, 1, 1, 1);

        e_rst = ev(0, 1, 1, 1, 0, 0, 0, 0);
        e_run = ev(6, 0, 0, 0, 1, 1, 0, 0);

        // Bring-up with all status held high: RUN 23 cycles after release.
        add("reset_values",    0, 0, 1, 1, 1, 2, e_rst);
        add("pll_rst_hold",    1, 0, 1, 1, 1, 3, e_rst);
        add("wait_lock",       1, 0, 1, 1, 1, 1, ev(1, 0, 1, 1, 0, 0, 0, 0));
        add("tx_rst_enter",    1, 0, 1, 1, 1, 1, ev(2, 0, 1, 1, 0, 0, 0, 0));
        add("tx_rst_last",     1, 0, 1, 1, 1, 7, ev(2, 0, 1, 1, 0, 0, 0, 0));
        add("wait_tx",         1, 0, 1, 1, 1, 1, ev(3, 0, 0, 1, 0, 0, 0, 0));
        add("rx_rst_enter",    1, 0, 1, 1, 1, 1, ev(4, 0, 0, 1, 0, 0, 0, 0));
        add("rx_rst_last",     1, 0, 1, 1, 1, 7, ev(4, 0, 0, 1, 0, 0, 0, 0));
        add("wait_rx",         1, 0, 1, 1, 1, 1, ev(5, 0, 0, 0, 0, 0, 0, 0));
        add("run",             1, 0, 1, 1, 1, 1, e_run);
        add("run_stable",      1, 0, 1, 1, 1, 5, e_run);
        // One-cycle lock glitch: seen by the FSM 4 edges later.
        add("lock_drop",       1, 0, 0, 1, 1, 1, e_run);
        add("lock_sync_delay", 1, 0, 1, 1, 1, 2, e_run);
        add("lock_loss",       1, 0, 1, 1, 1, 1, e_rst);
        add("relock_wait_rx",  1, 0, 1, 1, 1, 22, ev(5, 0, 0, 0, 0, 0, 0, 0));
        add("relock_run",      1, 0, 1, 1, 1, 1, e_run);
        // One-cycle RX ready glitch in RUN.
        add("rx_drop",         1, 0, 1, 1, 0, 1, e_run);
        add("rx_sync_delay",   1, 0, 1, 1, 1, 2, e_run);
`ifdef HSSI_RST_SEQ_RX_RECOVER_EN
        add("rx_loss",         1, 0, 1, 1, 1, 1, ev(4, 0, 0, 1, 1, 0, 0, 0));
        add("rx_recover_wait", 1, 0, 1, 1, 1, 8, ev(5, 0, 0, 0, 1, 0, 0, 0));
`else
        add("rx_loss",         1, 0, 1, 1, 1, 1, e_rst);
        add("rx_rebring_wait", 1, 0, 1, 1, 1, 22, ev(5, 0, 0, 0, 0, 0, 0, 0));
`endif
        add("rx_recover_run",  1, 0, 1, 1, 1, 1, e_run);
        // PLL never locks: three PLL_RST pulses, then FAIL; restart clears.
        add("nolock_reset",    0, 0, 0, 1, 1, 2, e_rst);
        add("nolock_wait1",    1, 0, 0, 1, 1, 4, ev(1, 0, 1, 1, 0, 0, 0, 0));
        add("nolock_last1",    1, 0, 0, 1, 1, 99, ev(1, 0, 1, 1, 0, 0, 0, 0));
        add("nolock_retry1",   1, 0, 0, 1, 1, 1, ev(0, 1, 1, 1, 0, 0, 0, 1));
        add("nolock_wait2",    1, 0, 0, 1, 1, 4, ev(1, 0, 1, 1, 0, 0, 0, 1));
        add("nolock_last2",    1, 0, 0, 1, 1, 99, ev(1, 0, 1, 1, 0, 0, 0, 1));
        add("nolock_retry2",   1, 0, 0, 1, 1, 1, ev(0, 1, 1, 1, 0, 0, 0, 2));
        add("nolock_wait3",    1, 0, 0, 1, 1, 4, ev(1, 0, 1, 1, 0, 0, 0, 2));
        add("nolock_fail",     1, 0, 0, 1, 1, 100, ev(7, 1, 1, 1, 0, 0, 1, 2));
        add("fail_sticky",     1, 0, 0, 1, 1, 10, ev(7, 1, 1, 1, 0, 0, 1, 2));
        add("restart",         1, 1, 0, 1, 1, 1, e_rst);
        add("restart_wait",    1, 0, 1, 1, 1, 4, ev(1, 0, 1, 1, 0, 0, 0, 0));
        add("restart_tx_rst",  1, 0, 1, 1, 1, 1, ev(2, 0, 1, 1, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rn, vecs[i].rq, vecs[i].lk, vecs[i].tr, vecs[i].rr);
            step(vecs[i].cyc);
            chk(vecs[i].name, vecs[i].exp);
        end

        // rst_n asserted during WAIT_TX, then a clean bring-up.
        drive(0, 0, 1, 0, 1);
        step(2);
        drive(1, 0, 1, 0, 1);
        step(13);
        chk("midrst_in_wait_tx", ev(3, 0, 0, 1, 0, 0, 0, 0));
        step(5);
        drive(0, 0, 1, 0, 1);
        step(1);
        chk("midrst_values", e_rst);
        drive(1, 0, 1, 1, 1);
        step(22);
        chk("midrst_wait_rx", ev(5, 0, 0, 0, 0, 0, 0, 0));
        step(1);
        chk("midrst_run", e_run);

        // WAIT_TX timeout with tx ready low, then ready arriving on the last
        // cycle of the second wait counts as success.
        drive(0, 0, 1, 0, 1);
        step(2);
        drive(1, 0, 1, 0, 1);
        step(13);
        chk("txto_wait_tx", ev(3, 0, 0, 1, 0, 0, 0, 0));
        step(99);
        chk("txto_last_cycle", ev(3, 0, 0, 1, 0, 0, 0, 0));
        step(1);
        chk("txto_retry", ev(2, 0, 1, 1, 0, 0, 0, 1));
        step(8);
        chk("txto_wait_tx2", ev(3, 0, 0, 1, 0, 0, 0, 1));
        step(96);
        drive(1, 0, 1, 1, 1);
        step(3);
        chk("txedge_before", ev(3, 0, 0, 1, 0, 0, 0, 1));
        step(1);
        chk("txedge_advance", ev(4, 0, 0, 1, 0, 0, 0, 1));
        step(9);
        chk("txedge_run_clears_retry", e_run);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hssi_reset_sequencer.md
# hssi_reset_sequencer

Bring-up and recovery sequencer for one HSSI port's PLL, TX PCS/PMA and RX PCS/PMA resets. It releases the resets in a fixed order (PLL, then TX, then RX) and waits for each stage's ready/lock status before advancing. Each wait has a timeout, and each timeout triggers a bounded retry. It sits between the port's PHY status outputs and the packet client, and drives the port-level reset inputs plus the link-ready qualifiers used by the MAC segment logic.

## Interface
Parameters:
- CNTR_BITS, 16: width of the shared stage counter.
- PLL_RST_CYC, 16: cycles pll_rst is held asserted per attempt (≥1).
- LOCK_TIMEOUT, 65535: max cycles waiting for pll_locked (< 2^CNTR_BITS).
- TX_DLY, 64: cycles tx_rst is held after lock (≥1).
- RX_DLY, 64: cycles rx_rst is held after TX ready (≥1).
- RDY_TIMEOUT, 65535: max cycles waiting for tx/rx ready (< 2^CNTR_BITS).
- MAX_RETRY, 3: timeouts tolerated before FAIL (1..15).

Ports (clock and reset first):
- clk, input, 1: single clock; all logic on rising edge.
- rst_n, input, 1: reset is synchronous and active-low.
- restart_req, input, 1: synchronous one-cycle soft restart request.
- pll_locked, input, 1: async PLL lock status.
- tx_ready_in, input, 1: async TX PHY ready.
- rx_ready_in, input, 1: async RX PHY ready.
- pll_rst, output, 1: PLL reset, active-high.
- tx_rst, output, 1: TX reset, active-high.
- rx_rst, output, 1: RX reset, active-high.
- tx_ready, output, 1: TX link usable.
- rx_ready, output, 1: RX link usable.
- fail, output, 1: retries exhausted.
- state, output, 3: current FSM state code.
- retry_cnt, output, 4: timeouts in the current bring-up.

## Operation
- pll_locked, tx_ready_in and rx_ready_in each pass through a 3-flop synchronizer. The FSM sees the synchronized values lock_s, txr_s and rxr_s.
- FSM state codes:
  - 0 PLL_RST: pll_rst=1. Exit to WAIT_LOCK after PLL_RST_CYC cycles.
  - 1 WAIT_LOCK: pll_rst=0. If lock_s=1, go to TX_RST. On timeout, take the retry path back to PLL_RST.
  - 2 TX_RST: tx_rst=1. Exit to WAIT_TX after TX_DLY cycles.
  - 3 WAIT_TX: tx_rst=0. If txr_s=1, go to RX_RST. On timeout, take the retry path back to TX_RST.
  - 4 RX_RST: rx_rst=1. Exit to WAIT_RX after RX_DLY cycles.
  - 5 WAIT_RX: rx_rst=0. If rxr_s=1, go to RUN. On timeout, take the retry path back to RX_RST.
  - 6 RUN: all resets 0, tx_ready=1, rx_ready=1.
  - 7 FAIL: all resets 1, fail=1. Only rst_n or restart_req exits.
- Outputs in states 0-5:
  - tx_rst=1 in states 0-2; rx_rst=1 in states 0-4.
  - tx_ready=1 only in RUN. rx_ready=1 only in RUN.
- Counter: cleared on every state entry, increments every cycle in timed states. A timed state exits when cnt == N-1, where N is that state's parameter.
- Timeout and retry:
  - A timeout occurs when cnt == timeout-1 without the awaited status.
  - If retry_cnt == MAX_RETRY-1, the FSM goes to FAIL. Otherwise retry_cnt increments.
  - retry_cnt clears on entering RUN and on restart.
- Lock loss: lock_s=0 in any state 2-6 forces PLL_RST. It does not increment retry_cnt.
- TX loss: txr_s=0 in state 4, 5 or 6 forces TX_RST. It does not increment retry_cnt.
- RX loss in RUN: rxr_s=0 is handled per Configuration.
- Priority, highest first: rst_n, restart_req, lock loss, TX loss, RX loss, timeout, normal advance.
- restart_req: from any state, go to PLL_RST next cycle and clear fail and retry_cnt.

## Timing
- Reset values (rst_n=0 sampled): state=0, pll_rst=1, tx_rst=1, rx_rst=1, tx_ready=0, rx_ready=0, fail=0, retry_cnt=0, counter=0.
- All outputs are registered and decoded from the next state, so they change in the same cycle as state.
- Status-to-FSM latency: 3 cycles of synchronizer plus 1 cycle of transition.
- Minimum bring-up with status already stable: PLL_RST_CYC + 1 + TX_DLY + 1 + RX_DLY + 1 cycles from reset release to RUN, plus synchronizer latency wherever status arrives late.
- A status that rises in the same cycle as its timeout counts as success, not timeout.
- rst_n asserted mid-sequence overrides everything; the next cycle shows the reset values.

## Configuration
- HSSI_RST_SEQ_RX_RECOVER_EN defined: rxr_s=0 in RUN goes to RX_RST only. TX stays up (tx_ready stays 1, tx_rst stays 0). retry_cnt is not incremented.
- HSSI_RST_SEQ_RX_RECOVER_EN undefined: rxr_s=0 in RUN goes to PLL_RST, giving a full re-bring-up.

## Test plan
- All status inputs held 1, PLL_RST_CYC=4, TX_DLY=RX_DLY=8 → RUN and tx_ready=rx_ready=1 exactly 4+1+8+1+8+1 cycles after rst_n rises, plus synchronizer latency.
- pll_locked held 0, LOCK_TIMEOUT=100, MAX_RETRY=3 → three PLL_RST pulses, retry_cnt steps 1,2, then fail=1 and state=7; restart_req clears fail and retry_cnt.
- RUN, then pll_locked drops for 1 cycle → within 4 cycles state=0, all resets 1, readies 0; bring-up repeats without a retry increment.
- RUN, then rx_ready_in drops → with the macro defined: state=4, tx_ready=1, rx_ready=0. With the macro undefined: state=0.
- rst_n pulled low during WAIT_TX → next cycle every output equals its reset value; bring-up restarts cleanly.
- tx_ready_in rises on exactly cycle RDY_TIMEOUT-1 of WAIT_TX → advance to RX_RST; retry_cnt unchanged.
